// File: rtl/proc_pkg.sv
// Shared processor constants: instruction field positions, FN opcodes,
// sequencer state type and T step encodings used by the sequencer and controller.
package proc_pkg;

  localparam int WORD_W  = 10;
  localparam int IMM_BIT = 9;
  localparam int SUB_BIT = 8;
  localparam int RX_HI   = 7;
  localparam int RX_LO   = 6;
  localparam int RY_HI   = 5;
  localparam int RY_LO   = 4;
  localparam int FN_HI   = 3;
  localparam int FN_LO   = 0;

  localparam logic [3:0] FN_LOAD = 4'b0000;
  localparam logic [3:0] FN_COPY = 4'b0001;
  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0011;
  localparam logic [3:0] FN_INV  = 4'b0100;
  localparam logic [3:0] FN_FLP  = 4'b0101;
  localparam logic [3:0] FN_AND  = 4'b0110;
  localparam logic [3:0] FN_OR   = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_LSL  = 4'b1001;
  localparam logic [3:0] FN_LSR  = 4'b1010;
  localparam logic [3:0] FN_ASR  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC
  } seq_state_t;

  localparam logic [1:0] T_0 = 2'd0;
  localparam logic [1:0] T_1 = 2'd1;
  localparam logic [1:0] T_2 = 2'd2;
  localparam logic [1:0] T_3 = 2'd3;

  // A LOAD is the only two-word instruction: register form with FN=LOAD.
  function automatic logic is_load(input logic [WORD_W-1:0] w);
    return !w[IMM_BIT] && (w[FN_HI:FN_LO] == FN_LOAD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; exposes the head and the word
// behind it so the sequencer can look ahead across a pop.
module sync_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [DW-1:0] o_second,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_rdNext;
  logic          w_push;
  logic          w_pop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && (r_count != '0);
  assign w_rdNext = r_rdPtr + AW'(1);
  assign o_head   = r_mem[r_rdPtr];
  assign o_second = r_mem[w_rdNext];
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= w_rdNext;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Producer side of the controller's INSTR/T/Clr interface: queues host words and
// issues them onto DIN, stepping T until the controller answers with Clr.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          run,
  input  logic          Clr,
  output logic [DW-1:0] DIN,
  output logic [1:0]    T,
  output logic          issue,
  output logic          busy,
  output logic          instr_done,
  output logic [CW-1:0] count,
  output logic          proto_err
);

  seq_state_t    r_state;
  seq_state_t    w_nextState;
  logic [1:0]    r_t;
  logic [1:0]    w_nextT;
  logic [DW-1:0] r_din;
  logic [DW-1:0] w_nextDin;
  logic          r_curLoad;
  logic          w_nextCurLoad;
  logic          r_proto;
  logic          w_setProto;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic [DW-1:0] w_head;
  logic [DW-1:0] w_second;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cntAfterPop;
  logic [CW-1:0] w_cntNext;
  logic [DW-1:0] w_headNext;
  logic          w_start;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_wdata  (din),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_second (w_second),
    .o_count  (w_count),
    .o_full   (w_full)
  );

  assign din_ready = rst_n && !w_full;
  assign w_push    = din_valid && din_ready;
  assign w_pop     = (r_state == ISSUE) || ((r_state == EXEC) && (r_t == T_1) && r_curLoad);

  // Start decision looks at the FIFO as it will be after this edge's pop and push,
  // so a freshly pushed word or the next queued word can issue without a bubble.
  always_comb begin
    w_cntAfterPop = w_count - CW'(w_pop);
    w_cntNext     = w_cntAfterPop + CW'(w_push);
    if (w_cntAfterPop == '0)
      w_headNext = din;
    else if (w_pop)
      w_headNext = w_second;
    else
      w_headNext = w_head;
    w_start = run && ((w_cntNext >= CW'(2)) ||
                      ((w_cntNext == CW'(1)) && !is_load(w_headNext)));
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextT       = r_t;
    w_nextDin     = r_din;
    w_nextCurLoad = r_curLoad;
    w_setProto    = 1'b0;
    issue         = 1'b0;
    instr_done    = 1'b0;
    DIN           = r_din;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_nextState = ISSUE;
      end
      ISSUE: begin
        issue         = 1'b1;
        DIN           = w_head;
        w_nextDin     = w_head;
        w_nextCurLoad = is_load(w_head);
        w_nextT       = T_1;
        w_nextState   = EXEC;
      end
      EXEC: begin
        if ((r_t == T_1) && r_curLoad) begin
          DIN       = w_head;
          w_nextDin = w_head;
        end
        if (Clr || (r_t == T_3)) begin
          instr_done  = 1'b1;
          w_setProto  = !Clr;
          w_nextT     = T_0;
          w_nextState = w_start ? ISSUE : IDLE;
        end else begin
          w_nextT = r_t + 2'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_t       <= T_0;
      r_din     <= '0;
      r_curLoad <= 1'b0;
      r_proto   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_t       <= w_nextT;
      r_din     <= w_nextDin;
      r_curLoad <= w_nextCurLoad;
      r_proto   <= r_proto | w_setProto;
    end
  end

  assign T         = r_t;
  assign busy      = (r_state != IDLE);
  assign count     = w_count;
  assign proto_err = r_proto;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_instr_sequencer;

  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          run = 1'b0;
  logic          Clr = 1'b0;
  logic [DW-1:0] DIN;
  logic [1:0]    T;
  logic          issue;
  logic          busy;
  logic          instr_done;
  logic [CW-1:0] count;
  logic          proto_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .run        (run),
    .Clr        (Clr),
    .DIN        (DIN),
    .T          (T),
    .issue      (issue),
    .busy       (busy),
    .instr_done (instr_done),
    .count      (count),
    .proto_err  (proto_err)
  );

  // Reference model: host queue plus "instruction in flight" and its cycle index.
  logic [DW-1:0] mQ[$];
  bit            mActive;
  int            mPhase;
  logic [DW-1:0] mCur;
  logic [DW-1:0] mHold;
  bit            mProto;

  function automatic bit isLoadWord(input logic [DW-1:0] w);
    return (w[9] == 1'b0) && (w[3:0] == 4'b0000);
  endfunction

  function automatic int instrLen(input logic [DW-1:0] w);
    if (w[9]) return 4;
    case (w[3:0])
      4'd0, 4'd1: return 2;
      4'd4, 4'd5: return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic bit canStart(input bit r);
    if (!r || mQ.size() == 0) return 1'b0;
    if (isLoadWord(mQ[0])) return mQ.size() >= 2;
    return 1'b1;
  endfunction

  function automatic bit ctrlClr();
    return mActive && (mPhase > 0) && (mPhase == instrLen(mCur) - 1);
  endfunction

  task automatic modelReset();
    mQ.delete();
    mActive = 1'b0;
    mPhase  = 0;
    mCur    = '0;
    mHold   = '0;
    mProto  = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bit doPush;
    bit endNow;
    doPush = v && (mQ.size() < DEPTH);
    endNow = 1'b0;
    if (mActive) begin
      if (mPhase == 0) begin
        mCur   = mQ.pop_front();
        mHold  = mCur;
        mPhase = 1;
      end else begin
        if (mPhase == 1 && isLoadWord(mCur)) mHold = mQ.pop_front();
        if (c || mPhase == 3) begin
          endNow = 1'b1;
          if (!c) mProto = 1'b1;
        end else begin
          mPhase++;
        end
      end
    end
    if (doPush) mQ.push_back(d);
    if (!mActive || endNow) begin
      mActive = canStart(r);
      mPhase  = 0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  task automatic checkModel();
    logic [DW-1:0] eDin;
    if (mActive && mPhase == 0) eDin = mQ[0];
    else if (mActive && mPhase == 1 && isLoadWord(mCur)) eDin = mQ[0];
    else eDin = mHold;
    checkOutput("model T",          32'(T),          mActive ? 32'(mPhase) : 32'd0);
    checkOutput("model issue",      32'(issue),      32'(mActive && mPhase == 0));
    checkOutput("model busy",       32'(busy),       32'(mActive));
    checkOutput("model instr_done", 32'(instr_done), 32'(mActive && mPhase > 0 && (Clr || mPhase == 3)));
    checkOutput("model count",      32'(count),      32'(mQ.size()));
    checkOutput("model din_ready",  32'(din_ready),  32'(mQ.size() < DEPTH));
    checkOutput("model DIN",        32'(DIN),        32'(eDin));
    checkOutput("model proto_err",  32'(proto_err),  32'(mProto));
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    run       = r;
    Clr       = c;
    #1;
    checkModel();
    modelStep(v, d, r, c);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " T"},          32'(T),          32'd0);
    checkOutput({tag, " issue"},      32'(issue),      32'd0);
    checkOutput({tag, " busy"},       32'(busy),       32'd0);
    checkOutput({tag, " instr_done"}, 32'(instr_done), 32'd0);
    checkOutput({tag, " count"},      32'(count),      32'd0);
    checkOutput({tag, " din_ready"},  32'(din_ready),  32'd0);
    checkOutput({tag, " DIN"},        32'(DIN),        32'd0);
    checkOutput({tag, " proto_err"},  32'(proto_err),  32'd0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    run       = 1'b0;
    Clr       = 1'b0;
    #1;
    checkResetState(tag);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    w       = DW'($urandom);
    w[3:0]  = 4'($urandom_range(0, 11));
    w[9]    = ($urandom_range(0, 99) < 20);
    return w;
  endfunction

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          c;
    logic [1:0]    eT;
    logic          eIssue;
    logic          eBusy;
    logic          eDone;
    logic [CW-1:0] eCount;
    logic [DW-1:0] eDin;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int busyCycles;
    int streaks;
    int issues;
    bit prevBusy;
    int budget;

    // Single ADD, then LOAD pairing.
    vecs[0]  = '{1'b1, 10'h062, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000};
    vecs[1]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd1, 10'h062};
    vecs[2]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 10'h062};
    vecs[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 10'h062};
    vecs[4]  = '{1'b0, 10'h000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 4'd0, 10'h062};
    vecs[5]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h062};
    vecs[6]  = '{1'b1, 10'h000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h062};
    vecs[7]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 10'h062};
    vecs[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 10'h062};
    vecs[9]  = '{1'b1, 10'h155, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 10'h062};
    vecs[10] = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd2, 10'h000};
    vecs[11] = '{1'b0, 10'h000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'd1, 10'h155};
    vecs[12] = '{1'b0, 10'h000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h155};

    modelReset();
    #1;
    checkResetState("por");
    doReset("reset");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      checkOutput($sformatf("vec%0d T", i),          32'(T),          32'(vecs[i].eT));
      checkOutput($sformatf("vec%0d issue", i),      32'(issue),      32'(vecs[i].eIssue));
      checkOutput($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d instr_done", i), 32'(instr_done), 32'(vecs[i].eDone));
      checkOutput($sformatf("vec%0d count", i),      32'(count),      32'(vecs[i].eCount));
      checkOutput($sformatf("vec%0d DIN", i),        32'(DIN),        32'(vecs[i].eDin));
    end

    // Back-to-back COPY, INV, SUB-immediate: 2+3+4 contiguous busy cycles.
    applyStimulus(1'b1, 10'h051, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h044, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h305, 1'b0, 1'b0);
    busyCycles = 0;
    streaks    = 0;
    issues     = 0;
    prevBusy   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 10'h000, 1'b1, ctrlClr());
      if (busy) busyCycles++;
      if (busy && !prevBusy) streaks++;
      if (issue) issues++;
      prevBusy = busy;
    end
    checkOutput("b2b busy cycles", 32'(busyCycles), 32'd9);
    checkOutput("b2b busy streaks", 32'(streaks), 32'd1);
    checkOutput("b2b issues", 32'(issues), 32'd3);

    // Fill with run=0, overflow push ignored, then start with din_valid held.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 10'h062, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    checkOutput("full din_ready", 32'(din_ready), 32'd0);
    checkOutput("full count", 32'(count), 32'(DEPTH));
    applyStimulus(1'b1, 10'h2A3, 1'b0, 1'b0);
    checkOutput("full push ignored", 32'(count), 32'(DEPTH));
    applyStimulus(1'b1, 10'h2A3, 1'b1, 1'b0);
    checkOutput("full start count", 32'(count), 32'(DEPTH));
    applyStimulus(1'b1, 10'h2A3, 1'b1, 1'b0);
    checkOutput("full issue", 32'(issue), 32'd1);
    checkOutput("full issue count", 32'(count), 32'(DEPTH));
    applyStimulus(1'b1, 10'h2A3, 1'b1, ctrlClr());
    checkOutput("full after pop count", 32'(count), 32'(DEPTH - 1));
    budget = 0;
    while ((mActive || mQ.size() != 0) && budget < 100) begin
      applyStimulus(1'b0, 10'h000, 1'b1, ctrlClr());
      budget++;
    end
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("full drained count", 32'(count), 32'd0);
    checkOutput("full drained busy", 32'(busy), 32'd0);

    // Controller never answers: T wraps, proto_err sticks, next word still issues.
    applyStimulus(1'b1, 10'h062, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'h0A2, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("noclr T3", 32'(T), 32'd3);
    checkOutput("noclr wrap done", 32'(instr_done), 32'd1);
    checkOutput("noclr proto before wrap", 32'(proto_err), 32'd0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("noclr proto set", 32'(proto_err), 32'd1);
    checkOutput("noclr next issue", 32'(issue), 32'd1);
    checkOutput("noclr next DIN", 32'(DIN), 32'h0A2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("noclr idle", 32'(busy), 32'd0);
    checkOutput("noclr proto sticky", 32'(proto_err), 32'd1);

    // Asynchronous reset in the middle of an ADD with three words queued.
    doReset("pre-midreset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10'(10'h062 + 10'(i * 32)), 1'b0, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("midreset at T2", 32'(T), 32'd2);
    checkOutput("midreset queued", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
      checkOutput("post-reset idle", 32'(busy), 32'd0);
    end

    // Random traffic against the model, with occasional stray or missing Clr.
    doReset("pre-random");
    for (int i = 0; i < 2000; i++) begin
      int roll;
      logic c;
      roll = $urandom_range(0, 99);
      if (roll < 90) c = ctrlClr();
      else if (roll < 95) c = 1'b1;
      else c = 1'b0;
      applyStimulus($urandom_range(0, 99) < 45, randWord(), $urandom_range(0, 99) < 85, c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Producer side of the controller's INSTR/T/Clr interface.
- Buffers 10-bit instruction words (and LOAD data words) from a host port in a FIFO.
- Drives them onto the processor's external data bus and generates the T timestep counter.
- Advances T each cycle until the controller asserts Clr, then issues the next instruction or goes idle.

Parameters:
- DW, 10, instruction/data word width
- DEPTH, 8, FIFO depth in words (power of two, >=2)
- CW, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  DW  host word (instruction or LOAD data)
- din_valid  input  1  host word valid
- din_ready  output  1  FIFO can accept; transfer when din_valid && din_ready
- run  input  1  permit starting new instructions
- Clr  input  1  controller end-of-instruction strobe
- DIN  output  DW  word driven to the external bus (IR load at T=0, Ext data at T=1)
- T  output  2  timestep to the controller
- issue  output  1  high only in ISSUE; datapath gates IRin with it
- busy  output  1  high in ISSUE or EXEC
- instr_done  output  1  one-cycle pulse when Clr ends an instruction
- count  output  CW  FIFO occupancy
- proto_err  output  1  sticky: T reached 3 without Clr and wrapped

Behaviour:
- Reset (async, rst_n=0) forces the following, even mid-instruction or mid-push; the FIFO is flushed.
  - FSM=IDLE, T=0, DIN=0, issue=0, busy=0, instr_done=0, proto_err=0, count=0, din_ready=0 while in reset.
- FIFO
  - din_ready = (count < DEPTH).
  - Push and pop in the same cycle are allowed; count is unchanged.
  - No push when full: din_valid is ignored and count stays DEPTH.
  - Pointers wrap modulo DEPTH.
- LOAD detection on the head word: bit9==0 and bits[3:0]==4'b0000. A LOAD is two words: instruction, then data.
- Start condition: run && (count>=2 if head is LOAD, else count>=1). A LOAD is never started without its data word present.
- FSM states: IDLE, ISSUE, EXEC.
- IDLE
  - T=0, issue=0, DIN holds its last value.
  - If the start condition holds: next state ISSUE.
- ISSUE (T=0)
  - DIN=head, issue=1.
  - On the edge: pop head, T<=1, go to EXEC.
- EXEC, T=1
  - If the issued word was a LOAD: DIN=head (data word), popped at the end of this cycle.
  - Otherwise DIN holds the instruction word.
- EXEC, any T
  - Clr=1: instr_done=1 that cycle; T<=0. Next state ISSUE if the start condition holds, evaluated on post-pop state; else IDLE.
  - Clr=0 and T<3: T<=T+1.
  - Clr=0 and T==3: set proto_err, T<=0, treat as end of instruction (instr_done=1).
- Clr sampled in IDLE or ISSUE is ignored.
- run deasserted mid-instruction: the current instruction completes, then the FSM returns to IDLE.
- Issue latency
  - Push into an empty FIFO at edge N (run=1): ISSUE during cycle N+1 (count=1 visible), T=1 during cycle N+2.
  - Back-to-back: T=0 (ISSUE) in the cycle immediately after the Clr cycle.
- Instruction lengths in cycles including ISSUE: LOAD/COPY 2, INV/FLP 3, ALU ops and immediate ops (bit9=1) 4.

Decomposition:
- Shared package proc_pkg holds:
  - FN opcode constants (LOAD..ASR, 4'b0000..4'b1011)
  - field positions: IMM flag bit9, SUB bit8, rx [7:6], ry [5:4], FN [3:0]
  - seq_state_t enum {IDLE, ISSUE, EXEC}
  - T step encodings
  - the controller moves to these same constants
- One sub-module: sync_fifo, parameterized DW/DEPTH, exposing head word, second word, count, push/pop.

Test Plan:
- Single ADD: push 10'h062 (ADD rx=1, ry=2) with run=1; controller model asserts Clr at T=3 -> ISSUE in cycle N+1 with DIN=10'h062 and issue=1; T sequence 0,1,2,3 starting at ISSUE; instr_done pulse at T=3; returns to IDLE with count=0.
- LOAD pairing:
  - push 10'h000 only -> stays IDLE, count=1.
  - push 10'h155 -> ISSUE with DIN=10'h000, then T=1 with DIN=10'h155.
  - Clr at T=1 -> count=0, instr_done pulse.
- Back-to-back: push COPY 10'h051, INV 10'h044, then SUB-immediate 10'h305 -> each ISSUE directly follows the prior Clr cycle; total 2+3+4=9 busy cycles.
- Full/simultaneous: fill 8 words with run=0 -> din_ready=0 and a 9th push is ignored; then set run=1 with din_valid held -> count stays 8 during the first pop+push cycle.
- Missing Clr: controller model never asserts Clr -> T wraps 3->0, proto_err=1 and stays set, next instruction issued.
- Reset mid-instruction: assert rst_n=0 at T=2 of an ADD with 3 words queued -> immediately T=0, busy=0, count=0, issue=0; after release stays IDLE.
